// File: rtl/line_point_sampler.sv
// line_point_sampler
// Scans the pixel stream, turns each qualifying mask pixel into one (x, y)
// sample for the regression stage, strobes tabulate_out once per frame after
// the last sample, then holds off new frames until the regression answers or
// the wait times out.
//
// Handshake: valid_out and tabulate_out are one-cycle strobes with no ready;
// the regression consumes every strobe it sees. regr_valid_in is a one-cycle
// strobe from the regression and is only acted on in WAIT_RESULT.
module line_point_sampler #(
    parameter int H_ACTIVE    = 1024,
    parameter int V_ACTIVE    = 768,
    parameter int Y_LIMIT     = 317,
    parameter int STRIDE_LOG2 = 0,
    parameter int MAX_POINTS  = 4096,
    parameter int TIMEOUT     = 2048
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        pixel_valid_in,
    input  logic        mask_in,
    input  logic        regr_valid_in,
    output logic [10:0] x_out,
    output logic [9:0]  y_out,
    output logic        valid_out,
    output logic        tabulate_out,
    output logic [12:0] count_out,
    output logic        busy_out,
    output logic        timeout_out,
    output logic [1:0]  state_out
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_FLUSH   = 2'd2,
        S_WAIT    = 2'd3
    } state_e;

    localparam int          TO_W     = $clog2(TIMEOUT) + 1;
    // Low column bits that must be zero; STRIDE_LOG2 = 0 gives an all-zero
    // mask, which disables the column filter.
    localparam logic [31:0] COL_MASK = (32'd1 << STRIDE_LOG2) - 32'd1;

    state_e            state_q;
    logic [10:0]       x_q;
    logic [9:0]        y_q;
    logic              valid_q;
    logic              tab_q;
    logic              timeout_q;
    logic [12:0]       count_q;
    logic [12:0]       point_cnt_q;
    logic [TO_W-1:0]   to_cnt_q;

    logic frame_start;
    logic frame_end;
    logic pix_ok;
    logic cap_ok;
    logic start_take;

    // Pixel classification: frame markers, qualification and sample cap.
    always_comb begin
        frame_start = pixel_valid_in && (hcount_in == 11'd0) && (vcount_in == 10'd0);
        frame_end   = pixel_valid_in
                      && (32'(hcount_in) == 32'(H_ACTIVE - 1))
                      && (32'(vcount_in) == 32'(V_ACTIVE - 1));
        pix_ok      = pixel_valid_in && mask_in
                      && (32'(vcount_in) < 32'(Y_LIMIT))
                      && ((32'(hcount_in) & COL_MASK) == 32'd0);
        cap_ok      = 32'(point_cnt_q) < 32'(MAX_POINTS);
        // On a frame start the count restarts from zero, so only a zero cap
        // can block the first pixel.
        start_take  = pix_ok && (MAX_POINTS > 0);
    end

    // Frame state machine with all outputs registered; strobes default low.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= S_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            valid_q     <= 1'b0;
            tab_q       <= 1'b0;
            timeout_q   <= 1'b0;
            count_q     <= '0;
            point_cnt_q <= '0;
            to_cnt_q    <= '0;
        end else begin
            valid_q   <= 1'b0;
            tab_q     <= 1'b0;
            timeout_q <= 1'b0;
            case (state_q)
                S_IDLE, S_COLLECT: begin
                    if (frame_start) begin
                        // New frame (or restart after a lost frame end):
                        // count restarts and this pixel is evaluated too.
                        state_q <= frame_end ? S_FLUSH : S_COLLECT;
                        if (start_take) begin
                            x_q         <= hcount_in;
                            y_q         <= vcount_in;
                            valid_q     <= 1'b1;
                            point_cnt_q <= 13'd1;
                        end else begin
                            point_cnt_q <= 13'd0;
                        end
                    end else if (state_q == S_COLLECT && pixel_valid_in) begin
                        if (pix_ok && cap_ok) begin
                            x_q         <= hcount_in;
                            y_q         <= vcount_in;
                            valid_q     <= 1'b1;
                            point_cnt_q <= point_cnt_q + 13'd1;
                        end
                        if (frame_end) begin
                            state_q <= S_FLUSH;
                        end
                    end
                end
                S_FLUSH: begin
                    // Tabulate one cycle after the last possible sample so the
                    // two strobes never coincide.
                    if (point_cnt_q != 13'd0) begin
                        tab_q    <= 1'b1;
                        count_q  <= point_cnt_q;
                        to_cnt_q <= '0;
                        state_q  <= S_WAIT;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (regr_valid_in) begin
                        state_q <= S_IDLE;
                    end else if (32'(to_cnt_q) == 32'(TIMEOUT - 1)) begin
                        timeout_q <= 1'b1;
                        state_q   <= S_IDLE;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Output drive: registered values, busy is a decode of the state register.
    always_comb begin
        x_out        = x_q;
        y_out        = y_q;
        valid_out    = valid_q;
        tabulate_out = tab_q;
        count_out    = count_q;
        timeout_out  = timeout_q;
        busy_out     = (state_q != S_IDLE);
        state_out    = state_q;
    end

endmodule

// File: tb/tb_line_point_sampler.sv
// Testbench for line_point_sampler: three instances with different
// qualification parameters share one pixel stream on a small 32x8 frame.
module tb_line_point_sampler;

    localparam int H  = 32;
    localparam int V  = 8;
    localparam int TO = 64;

    logic        clk;
    logic        rst_n;
    logic [10:0] hc;
    logic [9:0]  vc;
    logic        pv;
    logic        mask;
    logic        regr;

    logic [10:0] a_x, s_x, m_x;
    logic [9:0]  a_y, s_y, m_y;
    logic        a_v, s_v, m_v;
    logic        a_t, s_t, m_t;
    logic [12:0] a_c, s_c, m_c;
    logic        a_b, s_b, m_b;
    logic        a_to, s_to, m_to;
    logic [1:0]  a_st, s_st, m_st;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int end_cyc = 0;

    // monitor tallies
    int va_n = 0, vs_n = 0, vm_n = 0, sbad_n = 0;
    int ta_n = 0, ta_cyc = 0, to_n = 0, to_cyc = 0, ovl_n = 0;
    logic [20:0] got_q[$];
    logic [20:0] exp_q[$];

    line_point_sampler #(.H_ACTIVE(H), .V_ACTIVE(V), .Y_LIMIT(8), .STRIDE_LOG2(0),
                         .MAX_POINTS(64), .TIMEOUT(TO)) dut_a (
        .clk_in(clk), .rst_in(rst_n), .hcount_in(hc), .vcount_in(vc),
        .pixel_valid_in(pv), .mask_in(mask), .regr_valid_in(regr),
        .x_out(a_x), .y_out(a_y), .valid_out(a_v), .tabulate_out(a_t),
        .count_out(a_c), .busy_out(a_b), .timeout_out(a_to), .state_out(a_st));

    line_point_sampler #(.H_ACTIVE(H), .V_ACTIVE(V), .Y_LIMIT(4), .STRIDE_LOG2(2),
                         .MAX_POINTS(4096), .TIMEOUT(TO)) dut_s (
        .clk_in(clk), .rst_in(rst_n), .hcount_in(hc), .vcount_in(vc),
        .pixel_valid_in(pv), .mask_in(mask), .regr_valid_in(regr),
        .x_out(s_x), .y_out(s_y), .valid_out(s_v), .tabulate_out(s_t),
        .count_out(s_c), .busy_out(s_b), .timeout_out(s_to), .state_out(s_st));

    line_point_sampler #(.H_ACTIVE(H), .V_ACTIVE(V), .Y_LIMIT(8), .STRIDE_LOG2(0),
                         .MAX_POINTS(5), .TIMEOUT(TO)) dut_m (
        .clk_in(clk), .rst_in(rst_n), .hcount_in(hc), .vcount_in(vc),
        .pixel_valid_in(pv), .mask_in(mask), .regr_valid_in(regr),
        .x_out(m_x), .y_out(m_y), .valid_out(m_v), .tabulate_out(m_t),
        .count_out(m_c), .busy_out(m_b), .timeout_out(m_to), .state_out(m_st));

    // clock and cycle counter
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // output monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (a_v) begin
            va_n = va_n + 1;
            got_q.push_back({a_x, a_y});
        end
        if (a_t) begin
            ta_n   = ta_n + 1;
            ta_cyc = cyc;
        end
        if (a_to) begin
            to_n   = to_n + 1;
            to_cyc = cyc;
        end
        if (a_v && a_t) ovl_n = ovl_n + 1;
        if (s_v) begin
            vs_n = vs_n + 1;
            if (s_y >= 10'd4 || s_x[1:0] != 2'd0) sbad_n = sbad_n + 1;
        end
        if (m_v) vm_n = vm_n + 1;
    end

    function automatic logic mask_for(input int mode, input int h, input int v);
        case (mode)
            1: return (h == 10 && v == 1) || (h == 20 && v == 2) || (h == 30 && v == 3);
            2: return 1'b1;
            3: return (v == 1) && (h < 10);
            default: return 1'b0;
        endcase
    endfunction

    // driver tasks
    task automatic do_reset();
        rst_n = 1'b0;
        pv    = 1'b0;
        mask  = 1'b0;
        regr  = 1'b0;
        hc    = '0;
        vc    = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drives the first npix pixels of a frame in raster order, one per cycle.
    task automatic send_frame(input int mode, input int npix);
        int k = 0;
        for (int v = 0; v < V; v++) begin
            for (int h = 0; h < H; h++) begin
                if (k < npix) begin
                    @(posedge clk);
                    #1;
                    pv      = 1'b1;
                    hc      = 11'(h);
                    vc      = 10'(v);
                    mask    = mask_for(mode, h, v);
                    end_cyc = cyc;
                    k++;
                end
            end
        end
        @(posedge clk);
        #1;
        pv   = 1'b0;
        mask = 1'b0;
    endtask

    task automatic regr_pulse();
        @(posedge clk);
        #1 regr = 1'b1;
        @(posedge clk);
        #1 regr = 1'b0;
    endtask

    // tests
    task automatic test_reset();
        rst_n = 1'b0;
        pv    = 1'b0;
        mask  = 1'b0;
        regr  = 1'b0;
        hc    = '0;
        vc    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if ({a_x, a_y, a_c} !== 34'd0) begin
            n_fail++;
            $display("FAIL reset_data: got x=%0d y=%0d count=%0d expected 0", a_x, a_y, a_c);
        end
        n_tests++;
        if ({a_v, a_t, a_b, a_to} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got v/t/b/to=%b expected 0000", {a_v, a_t, a_b, a_to});
        end
        n_tests++;
        if (a_st !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %0d expected 0", a_st);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_three_points();
        int b_v, b_t;
        do_reset();
        b_v = va_n;
        b_t = ta_n;
        exp_q.delete();
        exp_q.push_back({11'd10, 10'd1});
        exp_q.push_back({11'd20, 10'd2});
        exp_q.push_back({11'd30, 10'd3});
        send_frame(1, H * V);
        repeat (4) @(negedge clk);
        n_tests++;
        if (va_n - b_v != 3) begin
            n_fail++;
            $display("FAIL three_count_valid: got %0d expected 3", va_n - b_v);
        end
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (b_v + i >= got_q.size()) begin
                n_fail++;
                $display("FAIL three_sample%0d: got none expected %h", i, exp_q[i]);
            end else if (got_q[b_v + i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL three_sample%0d: got %h expected %h", i, got_q[b_v + i], exp_q[i]);
            end
        end
        n_tests++;
        if (ta_n - b_t != 1) begin
            n_fail++;
            $display("FAIL three_tab_count: got %0d expected 1", ta_n - b_t);
        end
        n_tests++;
        if (ta_cyc != end_cyc + 2) begin
            n_fail++;
            $display("FAIL three_tab_time: got cycle %0d expected %0d", ta_cyc, end_cyc + 2);
        end
        n_tests++;
        if (a_c !== 13'd3) begin
            n_fail++;
            $display("FAIL three_count_out: got %0d expected 3", a_c);
        end
        regr_pulse();
    endtask

    task automatic test_stride();
        int b_s, b_bad, b_v;
        do_reset();
        b_s   = vs_n;
        b_bad = sbad_n;
        b_v   = va_n;
        send_frame(2, H * V);
        repeat (4) @(negedge clk);
        n_tests++;
        if (vs_n - b_s != 32) begin
            n_fail++;
            $display("FAIL stride_valid: got %0d expected 32", vs_n - b_s);
        end
        n_tests++;
        if (sbad_n - b_bad != 0) begin
            n_fail++;
            $display("FAIL stride_coords: got %0d bad samples expected 0", sbad_n - b_bad);
        end
        n_tests++;
        if (s_c !== 13'd32) begin
            n_fail++;
            $display("FAIL stride_count_out: got %0d expected 32", s_c);
        end
        n_tests++;
        if (va_n - b_v != 64 || a_c !== 13'd64) begin
            n_fail++;
            $display("FAIL cap64: got valid=%0d count=%0d expected 64/64", va_n - b_v, a_c);
        end
        regr_pulse();
    endtask

    task automatic test_max_points();
        int b_m, b_v;
        do_reset();
        b_m = vm_n;
        b_v = va_n;
        send_frame(3, H * V);
        repeat (4) @(negedge clk);
        n_tests++;
        if (vm_n - b_m != 5) begin
            n_fail++;
            $display("FAIL max_valid: got %0d expected 5", vm_n - b_m);
        end
        n_tests++;
        if (m_c !== 13'd5) begin
            n_fail++;
            $display("FAIL max_count_out: got %0d expected 5", m_c);
        end
        n_tests++;
        if (va_n - b_v != 10 || a_c !== 13'd10) begin
            n_fail++;
            $display("FAIL ten_points: got valid=%0d count=%0d expected 10/10", va_n - b_v, a_c);
        end
        regr_pulse();
    endtask

    task automatic test_empty_frame();
        int b_t, b_v;
        do_reset();
        send_frame(1, H * V);
        repeat (4) @(negedge clk);
        regr_pulse();
        b_t = ta_n;
        send_frame(0, H * V);
        @(negedge clk);
        n_tests++;
        if (a_b !== 1'b1 || a_st !== 2'd2) begin
            n_fail++;
            $display("FAIL empty_flush: got busy=%0d state=%0d expected 1/2", a_b, a_st);
        end
        @(negedge clk);
        n_tests++;
        if (a_b !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_busy: got %0d expected 0", a_b);
        end
        repeat (3) @(negedge clk);
        n_tests++;
        if (ta_n != b_t || a_c !== 13'd3) begin
            n_fail++;
            $display("FAIL empty_tab: got tabs=%0d count=%0d expected 0/3", ta_n - b_t, a_c);
        end
        b_v = va_n;
        send_frame(3, H * V);
        repeat (4) @(negedge clk);
        n_tests++;
        if (va_n - b_v != 10 || a_c !== 13'd10) begin
            n_fail++;
            $display("FAIL empty_next: got valid=%0d count=%0d expected 10/10", va_n - b_v, a_c);
        end
        regr_pulse();
    endtask

    task automatic test_timeout();
        int b_v, b_to, t1, b_t;
        do_reset();
        send_frame(1, H * V);
        repeat (4) @(negedge clk);
        t1   = ta_cyc;
        b_v  = va_n;
        b_to = to_n;
        send_frame(1, H * V);
        repeat (4) @(negedge clk);
        n_tests++;
        if (va_n - b_v != 0) begin
            n_fail++;
            $display("FAIL timeout_skip: got %0d samples expected 0", va_n - b_v);
        end
        n_tests++;
        if (to_n - b_to != 1) begin
            n_fail++;
            $display("FAIL timeout_pulses: got %0d expected 1", to_n - b_to);
        end
        n_tests++;
        if (to_cyc != t1 + TO) begin
            n_fail++;
            $display("FAIL timeout_time: got cycle %0d expected %0d", to_cyc, t1 + TO);
        end
        b_v = va_n;
        b_t = ta_n;
        send_frame(1, H * V);
        repeat (4) @(negedge clk);
        n_tests++;
        if (va_n - b_v != 3 || ta_n - b_t != 1 || a_c !== 13'd3) begin
            n_fail++;
            $display("FAIL timeout_next: got valid=%0d tabs=%0d count=%0d expected 3/1/3",
                     va_n - b_v, ta_n - b_t, a_c);
        end
    endtask

    task automatic test_regr_release();
        int b_to;
        do_reset();
        send_frame(1, H * V);
        repeat (3) @(negedge clk);
        b_to = to_n;
        while (cyc < ta_cyc + 40) @(posedge clk);
        #1 regr = 1'b1;
        @(negedge clk);
        n_tests++;
        if (a_b !== 1'b1) begin
            n_fail++;
            $display("FAIL regr_wait_busy: got %0d expected 1", a_b);
        end
        @(posedge clk);
        #1 regr = 1'b0;
        @(negedge clk);
        n_tests++;
        if (a_b !== 1'b0 || a_st !== 2'd0) begin
            n_fail++;
            $display("FAIL regr_idle: got busy=%0d state=%0d expected 0/0", a_b, a_st);
        end
        repeat (80) @(negedge clk);
        n_tests++;
        if (to_n != b_to) begin
            n_fail++;
            $display("FAIL regr_no_timeout: got %0d pulses expected 0", to_n - b_to);
        end
    endtask

    task automatic test_async_reset();
        int b_v;
        do_reset();
        send_frame(1, H * V);
        repeat (3) @(negedge clk);
        regr_pulse();
        // stop right after pixel (5,1), which qualifies
        send_frame(3, 38);
        @(negedge clk);
        n_tests++;
        if (a_v !== 1'b1 || a_b !== 1'b1 || a_c !== 13'd3) begin
            n_fail++;
            $display("FAIL pre_reset: got v=%0d busy=%0d count=%0d expected 1/1/3", a_v, a_b, a_c);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({a_x, a_y, a_c} !== 34'd0 || {a_v, a_t, a_b, a_to} !== 4'b0000) begin
            n_fail++;
            $display("FAIL async_reset: got x=%0d y=%0d count=%0d flags=%b expected all 0",
                     a_x, a_y, a_c, {a_v, a_t, a_b, a_to});
        end
        @(negedge clk);
        rst_n = 1'b1;
        b_v = va_n;
        send_frame(1, H * V);
        repeat (4) @(negedge clk);
        n_tests++;
        if (va_n - b_v != 3 || a_c !== 13'd3) begin
            n_fail++;
            $display("FAIL after_reset: got valid=%0d count=%0d expected 3/3", va_n - b_v, a_c);
        end
    endtask

    task automatic test_no_overlap();
        n_tests++;
        if (ovl_n != 0) begin
            n_fail++;
            $display("FAIL strobe_overlap: got %0d cycles expected 0", ovl_n);
        end
    endtask

    initial begin
        test_reset();
        test_three_points();
        test_stride();
        test_max_points();
        test_empty_frame();
        test_timeout();
        test_regr_release();
        test_async_reset();
        test_no_overlap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
